// File: rtl/ae_seq_pkg.sv
// -----------------------------------------------------------------------------
// ae_seq_pkg
// Shared definitions for the autoencoder layer sequencer.
//   CNT_W_DEF    default width of the input/output index buses
//   state_e      3-bit sequencer state encoding
//   STALL_CNT_W  width of the optional stall-cycle counter
//                (present only when AE_SEQ_STALL_CNT_EN is defined)
// -----------------------------------------------------------------------------
package ae_seq_pkg;

    localparam int CNT_W_DEF   = 5;
    localparam int STALL_CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CLR  = 3'd1,
        ST_MAC  = 3'd2,
        ST_ACT  = 3'd3,
        ST_WR   = 3'd4,
        ST_DONE = 3'd5
    } state_e;

endpackage : ae_seq_pkg

// File: rtl/ae_seq_out_counter.sv
// -----------------------------------------------------------------------------
// ae_seq_out_counter
// Registered output-neuron index with clear, increment and terminal flag.
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset (index -> 0)
//   i_clr    in   synchronous clear to 0 (wins over i_inc)
//   i_inc    in   synchronous increment
//   o_idx    out  current neuron index
//   o_last   out  high when o_idx is the last neuron (N-1)
// -----------------------------------------------------------------------------
module ae_seq_out_counter
    import ae_seq_pkg::*;
#(
    parameter int W = CNT_W_DEF,
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_idx,
    output logic         o_last
);

    localparam logic [W-1:0] LAST_IDX = W'(N - 1);

    logic [W-1:0] r_idx;

    // NOTE: clocked state is always written with non-blocking assignments so
    // every register samples its inputs from before the edge, regardless of
    // the order in which the simulator evaluates the processes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (i_clr) begin
            r_idx <= '0;
        end else if (i_inc) begin
            r_idx <= r_idx + W'(1);
        end
    end

    assign o_idx  = r_idx;
    assign o_last = (r_idx == LAST_IDX);

endmodule : ae_seq_out_counter

// File: rtl/ae_layer_sequencer.sv
// -----------------------------------------------------------------------------
// ae_layer_sequencer
// Sequences one fully-connected autoencoder layer. For every output neuron:
// clear the MAC, step the input index through N_IN inputs, apply the
// activation, write the result. The input index lives in an external,
// non-reset count register: this block drives its next value (cnt_d) and
// consumes its registered value (cnt_q).
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   start         layer start request, honoured in IDLE only
//   stall         datapath not ready; freezes MAC stepping
//   cnt_q         registered input index from the count register
//   cnt_d         next input index to the count register
//   in_idx        input/weight address (= cnt_q)
//   out_idx       current neuron index
//   mac_clr       clear accumulator
//   mac_en        accumulate current input x weight
//   act_en        apply activation
//   wr_en         write activated result at out_idx
//   busy          high in every state except IDLE
//   done          one-cycle end-of-layer pulse
//   stall_cycles  count of stalled MAC cycles (AE_SEQ_STALL_CNT_EN only)
//
// Build option: define AE_SEQ_STALL_CNT_EN to add the stall-cycle counter.
// -----------------------------------------------------------------------------
module ae_layer_sequencer
    import ae_seq_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int N_IN  = 16,
    parameter int N_OUT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stall,
    input  logic [CNT_W-1:0] cnt_q,
    output logic [CNT_W-1:0] cnt_d,
    output logic [CNT_W-1:0] in_idx,
    output logic [CNT_W-1:0] out_idx,
    output logic             mac_clr,
    output logic             mac_en,
    output logic             act_en,
    output logic             wr_en,
    output logic             busy,
    output logic             done
`ifdef AE_SEQ_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cycles
`endif
);

    // With N_IN = 2^CNT_W this is all-ones; the natural +1 wrap and the
    // forced zero on the last accumulate then agree, so no alias occurs.
    localparam logic [CNT_W-1:0] LAST_IN = CNT_W'(N_IN - 1);

    state_e r_state;
    state_e w_state_nxt;
    logic   w_out_clr;
    logic   w_out_inc;
    logic   w_out_last;

    // -------------------------------------------------------------------------
    // Output-neuron index
    // -------------------------------------------------------------------------
    ae_seq_out_counter #(
        .W (CNT_W),
        .N (N_OUT)
    ) u_out_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_out_clr),
        .i_inc  (w_out_inc),
        .o_idx  (out_idx),
        .o_last (w_out_last)
    );

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output decode
    // -------------------------------------------------------------------------
    // The count register has no reset, so cnt_q is never trusted in IDLE or
    // CLR: driving cnt_d = 0 there guarantees cnt_q = 0 on the first MAC.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // through the case can leave it unassigned and infer a latch.
        w_state_nxt = r_state;
        cnt_d       = '0;
        mac_clr     = 1'b0;
        mac_en      = 1'b0;
        act_en      = 1'b0;
        wr_en       = 1'b0;
        done        = 1'b0;
        busy        = 1'b1;
        w_out_clr   = 1'b0;
        w_out_inc   = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_out_clr   = 1'b1;
                    w_state_nxt = ST_CLR;
                end
            end

            ST_CLR: begin
                mac_clr     = 1'b1;
                w_state_nxt = ST_MAC;
            end

            ST_MAC: begin
                if (stall) begin
                    cnt_d = cnt_q;
                end else begin
                    mac_en = 1'b1;
                    if (cnt_q == LAST_IN) begin
                        cnt_d       = '0;
                        w_state_nxt = ST_ACT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_ACT: begin
                act_en      = 1'b1;
                w_state_nxt = ST_WR;
            end

            ST_WR: begin
                wr_en = 1'b1;
                if (w_out_last) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_out_inc   = 1'b1;
                    w_state_nxt = ST_CLR;
                end
            end

            ST_DONE: begin
                done        = 1'b1;
                w_out_clr   = 1'b1;
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign in_idx = cnt_q;

`ifdef AE_SEQ_STALL_CNT_EN
    // -------------------------------------------------------------------------
    // Stalled-MAC cycle counter: cleared on start accept, saturating, and
    // left untouched after done so it can be read until the next layer.
    // -------------------------------------------------------------------------
    logic [STALL_CNT_W-1:0] r_stall_cycles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
        end else if (r_state == ST_IDLE && start) begin
            r_stall_cycles <= '0;
        end else if (r_state == ST_MAC && stall && r_stall_cycles != '1) begin
            r_stall_cycles <= r_stall_cycles + STALL_CNT_W'(1);
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

endmodule : ae_layer_sequencer
